// File: rtl/hwpe_ctrl_bist_pkg.sv
// Shared types and the March C- element table for the HWPE control register file self-test.
package hwpe_ctrl_bist_pkg;

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    M0_W0_UP   = 3'd1,
    M1_R0W1_UP = 3'd2,
    M2_R1W0_UP = 3'd3,
    M3_R0W1_DN = 3'd4,
    M4_R1W0_DN = 3'd5,
    M5_R0_DN   = 3'd6,
    DONE       = 3'd7
  } march_state_e;

  localparam int unsigned NumMarchElements = 6;

  typedef struct packed {
    logic dir_dn;     // walk Depth-1..0 instead of 0..Depth-1
    logic has_read;
    logic exp_val;    // expected bit replicated over the word
    logic has_write;
    logic wr_val;     // written bit replicated over the word
  } march_elem_t;

  // Entry i describes march state M<i>; the enum value of M<i> is i+1.
  localparam march_elem_t MarchTable [NumMarchElements] = '{
    '{dir_dn: 1'b0, has_read: 1'b0, exp_val: 1'b0, has_write: 1'b1, wr_val: 1'b0},
    '{dir_dn: 1'b0, has_read: 1'b1, exp_val: 1'b0, has_write: 1'b1, wr_val: 1'b1},
    '{dir_dn: 1'b0, has_read: 1'b1, exp_val: 1'b1, has_write: 1'b1, wr_val: 1'b0},
    '{dir_dn: 1'b1, has_read: 1'b1, exp_val: 1'b0, has_write: 1'b1, wr_val: 1'b1},
    '{dir_dn: 1'b1, has_read: 1'b1, exp_val: 1'b1, has_write: 1'b1, wr_val: 1'b0},
    '{dir_dn: 1'b1, has_read: 1'b1, exp_val: 1'b0, has_write: 1'b0, wr_val: 1'b0}
  };

  // Element descriptor for a state; IDLE and DONE map to an all-zero (inactive) entry.
  function automatic march_elem_t march_elem(march_state_e s);
    logic [2:0] idx;
    idx = 3'(s) - 3'd1;
    if (s == IDLE || s == DONE) return '0;
    return MarchTable[idx];
  endfunction

endpackage

// File: rtl/hwpe_ctrl_march_fsm.sv
// March C- sequencer: walks the address space per element, compares reads and captures pass/fail.
module hwpe_ctrl_march_fsm
  import hwpe_ctrl_bist_pkg::*;
#(
  parameter int unsigned AddrWidth = 5,
  parameter int unsigned DataWidth = 32
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 start_i,
  input  logic                 abort_i,
  input  logic [DataWidth-1:0] rd_data_i,
  output logic                 busy_o,
  output logic                 done_o,
  output logic                 pass_o,
  output logic [AddrWidth-1:0] fail_addr_o,
  output logic [AddrWidth-1:0] addr_o,
  output logic                 we_o,
  output logic [DataWidth-1:0] wdata_o
);

  localparam logic [AddrWidth-1:0] LastAddr = '1;

  march_state_e         state_q, state_d;
  logic [AddrWidth-1:0] addr_q, addr_d;
  logic [AddrWidth-1:0] fail_addr_q, fail_addr_d;
  logic                 fail_q, fail_d;
  logic                 pass_q, pass_d;
  march_elem_t          elem, next_elem;
  logic                 in_march, terminal, mismatch;

  assign elem     = march_elem(state_q);
  assign in_march = (state_q != IDLE) && (state_q != DONE);
  assign terminal = elem.dir_dn ? (addr_q == '0) : (addr_q == LastAddr);
  assign mismatch = in_march && elem.has_read && (rd_data_i != {DataWidth{elem.exp_val}});

  // NOTE: every variable written here gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    fail_d      = fail_q;
    fail_addr_d = fail_addr_q;
    pass_d      = pass_q;
    next_elem   = '0;

    unique case (state_q)
      IDLE: begin
        if (start_i && !abort_i) begin
          state_d     = M0_W0_UP;
          addr_d      = '0;
          fail_d      = 1'b0;
          fail_addr_d = '0;
          pass_d      = 1'b0;
        end
      end
      DONE: state_d = IDLE;
      default: begin
        // Only the first miscompare is recorded; the walk always runs to the end.
        if (mismatch && !fail_q) begin
          fail_d      = 1'b1;
          fail_addr_d = addr_q;
        end
        if (terminal) begin
          state_d   = march_state_e'(3'(state_q) + 3'd1);
          next_elem = march_elem(state_d);
          addr_d    = next_elem.dir_dn ? LastAddr : '0;
          if (state_d == DONE) pass_d = !fail_d;
        end else begin
          addr_d = elem.dir_dn ? addr_q - AddrWidth'(1) : addr_q + AddrWidth'(1);
        end
      end
    endcase

    if (abort_i && in_march) begin
      state_d = IDLE;
      addr_d  = '0;
      pass_d  = 1'b0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      fail_q      <= 1'b0;
      fail_addr_q <= '0;
      pass_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      fail_q      <= fail_d;
      fail_addr_q <= fail_addr_d;
      pass_q      <= pass_d;
    end
  end

  assign busy_o      = in_march;
  assign done_o      = (state_q == DONE);
  assign pass_o      = pass_q;
  assign fail_addr_o = fail_addr_q;
  assign addr_o      = addr_q;
  assign we_o        = in_march && elem.has_write;
  assign wdata_o     = {DataWidth{elem.wr_val}};

endmodule

// File: rtl/hwpe_ctrl_regfile_bist.sv
// HWPE control register file: registered multi-port reads, byte-enabled write, built-in March C- test.
module hwpe_ctrl_regfile_bist
  import hwpe_ctrl_bist_pkg::*;
#(
  parameter int unsigned  AddrWidth    = 5,
  parameter int unsigned  DataWidth    = 32,
  parameter int unsigned  NumReadPorts = 2,
  localparam int unsigned NumByte      = DataWidth / 8,
  localparam int unsigned Depth        = 2 ** AddrWidth
) (
  input  logic                                      clk_i,
  input  logic                                      rst_ni,
  input  logic                                      clear_i,
  input  logic [NumReadPorts-1:0]                   rd_en_i,
  input  logic [NumReadPorts-1:0][AddrWidth-1:0]    rd_addr_i,
  output logic [NumReadPorts-1:0][DataWidth-1:0]    rd_data_o,
  input  logic                                      wr_en_i,
  input  logic [AddrWidth-1:0]                      wr_addr_i,
  input  logic [DataWidth-1:0]                      wr_data_i,
  input  logic [NumByte-1:0]                        wr_be_i,
  output logic [Depth-1:0][DataWidth-1:0]           mem_content_o,
  input  logic                                      bist_start_i,
  output logic                                      bist_busy_o,
  output logic                                      bist_done_o,
  output logic                                      bist_pass_o,
  output logic [AddrWidth-1:0]                      bist_fail_addr_o,
  input  logic                                      dbg_stuck_en_i,
  input  logic [AddrWidth-1:0]                      dbg_stuck_addr_i
);

  logic [Depth-1:0][DataWidth-1:0]        mem_q;
  logic [NumReadPorts-1:0][DataWidth-1:0] rd_data_q;

  logic                 bist_busy, bist_we;
  logic [AddrWidth-1:0] bist_addr;
  logic [DataWidth-1:0] bist_wdata;

  logic                 wr_en_int;
  logic [AddrWidth-1:0] wr_addr_int;
  logic [DataWidth-1:0] wr_data_int;
  logic [NumByte-1:0]   wr_be_int;
  logic [DataWidth-1:0] wr_word;

  hwpe_ctrl_march_fsm #(
    .AddrWidth(AddrWidth),
    .DataWidth(DataWidth)
  ) i_march_fsm (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .start_i    (bist_start_i),
    .abort_i    (clear_i),
    .rd_data_i  (mem_q[bist_addr]),
    .busy_o     (bist_busy),
    .done_o     (bist_done_o),
    .pass_o     (bist_pass_o),
    .fail_addr_o(bist_fail_addr_o),
    .addr_o     (bist_addr),
    .we_o       (bist_we),
    .wdata_o    (bist_wdata)
  );

  // While the march runs it owns the write port with all lanes enabled.
  always_comb begin
    wr_en_int   = wr_en_i;
    wr_addr_int = wr_addr_i;
    wr_data_int = wr_data_i;
    wr_be_int   = wr_be_i;
    if (bist_busy) begin
      wr_en_int   = bist_we;
      wr_addr_int = bist_addr;
      wr_data_int = bist_wdata;
      wr_be_int   = '1;
    end
  end

  // Merge enabled lanes into the current word, then apply the injected stuck-at-0 on bit 0.
  always_comb begin
    wr_word = mem_q[wr_addr_int];
    for (int b = 0; b < NumByte; b++) begin
      if (wr_be_int[b]) wr_word[b*8 +: 8] = wr_data_int[b*8 +: 8];
    end
    if (dbg_stuck_en_i && (wr_addr_int == dbg_stuck_addr_i) && wr_be_int[0]) begin
      wr_word[0] = 1'b0;
    end
  end

  // NOTE: storage is flop-based and must read as zero after reset, so it is reset like any other register.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      mem_q <= '0;
    end else if (clear_i) begin
      mem_q <= '0;
    end else if (wr_en_int) begin
      mem_q[wr_addr_int] <= wr_word;
    end
  end

  // Reads sample pre-write storage, so a same-cycle write to the same word returns old data.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      rd_data_q <= '0;
    end else if (clear_i) begin
      rd_data_q <= '0;
    end else if (!bist_busy) begin
      for (int p = 0; p < NumReadPorts; p++) begin
        if (rd_en_i[p]) rd_data_q[p] <= mem_q[rd_addr_i[p]];
      end
    end
  end

  assign rd_data_o     = rd_data_q;
  assign mem_content_o = mem_q;
  assign bist_busy_o   = bist_busy;

endmodule

// File: tb/tb_hwpe_ctrl_regfile_bist.sv
// Self-checking bench for hwpe_ctrl_regfile_bist: table-driven port vectors plus BIST sequences.
module tb_hwpe_ctrl_regfile_bist;

  localparam int AW = 5;
  localparam int DW = 32;
  localparam int NP = 2;
  localparam int NB = DW / 8;
  localparam int DEPTH = 2 ** AW;

  logic                   clk_i = 1'b0;
  logic                   rst_ni;
  logic                   clear_i;
  logic [NP-1:0]          rd_en_i;
  logic [NP-1:0][AW-1:0]  rd_addr_i;
  logic [NP-1:0][DW-1:0]  rd_data_o;
  logic                   wr_en_i;
  logic [AW-1:0]          wr_addr_i;
  logic [DW-1:0]          wr_data_i;
  logic [NB-1:0]          wr_be_i;
  logic [DEPTH-1:0][DW-1:0] mem_content_o;
  logic                   bist_start_i;
  logic                   bist_busy_o;
  logic                   bist_done_o;
  logic                   bist_pass_o;
  logic [AW-1:0]          bist_fail_addr_o;
  logic                   dbg_stuck_en_i;
  logic [AW-1:0]          dbg_stuck_addr_i;

  hwpe_ctrl_regfile_bist #(
    .AddrWidth   (AW),
    .DataWidth   (DW),
    .NumReadPorts(NP)
  ) dut (
    .clk_i           (clk_i),
    .rst_ni          (rst_ni),
    .clear_i         (clear_i),
    .rd_en_i         (rd_en_i),
    .rd_addr_i       (rd_addr_i),
    .rd_data_o       (rd_data_o),
    .wr_en_i         (wr_en_i),
    .wr_addr_i       (wr_addr_i),
    .wr_data_i       (wr_data_i),
    .wr_be_i         (wr_be_i),
    .mem_content_o   (mem_content_o),
    .bist_start_i    (bist_start_i),
    .bist_busy_o     (bist_busy_o),
    .bist_done_o     (bist_done_o),
    .bist_pass_o     (bist_pass_o),
    .bist_fail_addr_o(bist_fail_addr_o),
    .dbg_stuck_en_i  (dbg_stuck_en_i),
    .dbg_stuck_addr_i(dbg_stuck_addr_i)
  );

  always #5 clk_i = ~clk_i;

  int n_checks = 0;
  int n_fails  = 0;

  typedef struct {
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] wr_data;
    logic [NB-1:0] wr_be;
    logic [NP-1:0] rd_en;
    logic [AW-1:0] rd_addr0;
    logic [AW-1:0] rd_addr1;
    logic [DW-1:0] exp0;
    logic [DW-1:0] exp1;
  } vec_t;

  typedef struct {
    logic [DW-1:0] e0;
    logic [DW-1:0] e1;
    int            row;
  } rd_exp_t;

  typedef struct {
    int            cycles;
    logic          pass;
    logic          chk_addr;
    logic [AW-1:0] fail_addr;
  } bist_exp_t;

  vec_t      vecs [12];
  rd_exp_t   rd_q [$];
  bist_exp_t bist_q [$];

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fails++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic idle_inputs();
    clear_i      = 1'b0;
    rd_en_i      = '0;
    rd_addr_i    = '0;
    wr_en_i      = 1'b0;
    wr_addr_i    = '0;
    wr_data_i    = '0;
    wr_be_i      = '0;
    bist_start_i = 1'b0;
  endtask

  function automatic int nonzero_words();
    int n = 0;
    for (int i = 0; i < DEPTH; i++) if (mem_content_o[i] != '0) n++;
    return n;
  endfunction

  task automatic write_word(input logic [AW-1:0] a, input logic [DW-1:0] d);
    wr_en_i = 1'b1; wr_addr_i = a; wr_data_i = d; wr_be_i = '1;
    step();
    idle_inputs();
  endtask

  task automatic read_port0(input logic [AW-1:0] a);
    rd_en_i = 2'b01; rd_addr_i[0] = a;
    step();
    idle_inputs();
  endtask

  task automatic start_bist(input logic pass, input logic chk_addr, input logic [AW-1:0] fa);
    bist_q.push_back('{cycles: 6 * DEPTH, pass: pass, chk_addr: chk_addr, fail_addr: fa});
    bist_start_i = 1'b1;
    step();
    bist_start_i = 1'b0;
  endtask

  // Counts busy cycles until the march ends; poke drives ignored traffic and a second start.
  task automatic finish_bist(input bit poke);
    int        cycles = 0;
    bist_exp_t e;
    while (bist_busy_o && cycles < 1000) begin
      cycles++;
      if (poke) begin
        bist_start_i = (cycles == 10);
        rd_en_i      = '1;
        rd_addr_i    = '{5'd5, 5'd5};
        wr_en_i      = 1'b1;
        wr_addr_i    = 5'd5;
        wr_data_i    = '0;
        wr_be_i      = '1;
      end
      step();
    end
    idle_inputs();
    check("bist_no_timeout", DW'(cycles < 1000), 1);
    e = bist_q.pop_front();
    check("bist_busy_cycles", cycles, e.cycles);
    check("bist_done_pulse", bist_done_o, 1);
    check("bist_pass", bist_pass_o, e.pass);
    if (e.chk_addr) check("bist_fail_addr", bist_fail_addr_o, e.fail_addr);
    step();
    check("bist_done_one_cycle", bist_done_o, 0);
    check("bist_idle_after_done", bist_busy_o, 0);
    check("bist_pass_sticky", bist_pass_o, e.pass);
    check("mem_zero_after_bist", nonzero_words(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int done_cnt;
    rd_exp_t r;

    // Port vectors; reads appear on rd_data_o right after the edge that samples rd_en_i.
    vecs[0]  = '{1'b1, 5'd3,  32'hA5A5A5A5, 4'b0101, 2'b00, 5'd0, 5'd0,  32'h0,        32'h0};
    vecs[1]  = '{1'b0, 5'd0,  32'h0,        4'b0000, 2'b01, 5'd3, 5'd0,  32'h00A500A5, 32'h0};
    vecs[2]  = '{1'b1, 5'd7,  32'h11111111, 4'b1111, 2'b11, 5'd7, 5'd7,  32'h0,        32'h0};
    vecs[3]  = '{1'b0, 5'd0,  32'h0,        4'b0000, 2'b11, 5'd7, 5'd7,  32'h11111111, 32'h11111111};
    vecs[4]  = '{1'b0, 5'd0,  32'h0,        4'b0000, 2'b10, 5'd0, 5'd3,  32'h11111111, 32'h00A500A5};
    vecs[5]  = '{1'b1, 5'd3,  32'hDEADBEEF, 4'b1010, 2'b01, 5'd3, 5'd0,  32'h00A500A5, 32'h00A500A5};
    vecs[6]  = '{1'b0, 5'd0,  32'h0,        4'b0000, 2'b11, 5'd3, 5'd31, 32'hDEA5BEA5, 32'h0};
    vecs[7]  = '{1'b1, 5'd31, 32'hFFFFFFFF, 4'b1000, 2'b11, 5'd0, 5'd31, 32'h0,        32'h0};
    vecs[8]  = '{1'b0, 5'd0,  32'h0,        4'b0000, 2'b10, 5'd0, 5'd31, 32'h0,        32'hFF000000};
    vecs[9]  = '{1'b1, 5'd0,  32'hFFFFFFFF, 4'b0000, 2'b00, 5'd0, 5'd0,  32'h0,        32'hFF000000};
    vecs[10] = '{1'b0, 5'd0,  32'h0,        4'b0000, 2'b11, 5'd0, 5'd31, 32'h0,        32'hFF000000};
    vecs[11] = '{1'b0, 5'd0,  32'h0,        4'b0000, 2'b01, 5'd3, 5'd0,  32'hDEA5BEA5, 32'hFF000000};

    idle_inputs();
    dbg_stuck_en_i   = 1'b0;
    dbg_stuck_addr_i = '0;
    rst_ni = 1'b0;
    step();
    step();
    rst_ni = 1'b1;

    check("reset_rd0", rd_data_o[0], 0);
    check("reset_rd1", rd_data_o[1], 0);
    check("reset_busy", bist_busy_o, 0);
    check("reset_done", bist_done_o, 0);
    check("reset_pass", bist_pass_o, 0);
    check("reset_fail_addr", bist_fail_addr_o, 0);
    check("reset_mem_zero", nonzero_words(), 0);

    for (int i = 0; i < 12; i++) begin
      wr_en_i      = vecs[i].wr_en;
      wr_addr_i    = vecs[i].wr_addr;
      wr_data_i    = vecs[i].wr_data;
      wr_be_i      = vecs[i].wr_be;
      rd_en_i      = vecs[i].rd_en;
      rd_addr_i[0] = vecs[i].rd_addr0;
      rd_addr_i[1] = vecs[i].rd_addr1;
      rd_q.push_back('{e0: vecs[i].exp0, e1: vecs[i].exp1, row: i});
      step();
      r = rd_q.pop_front();
      check($sformatf("vec%0d_rd0", r.row), rd_data_o[0], r.e0);
      check($sformatf("vec%0d_rd1", r.row), rd_data_o[1], r.e1);
    end
    idle_inputs();

    // Clear beats a same-cycle write and zeroes the read registers.
    clear_i = 1'b1; wr_en_i = 1'b1; wr_addr_i = 5'd3; wr_data_i = 32'h55555555; wr_be_i = '1;
    step();
    idle_inputs();
    check("clear_rd0", rd_data_o[0], 0);
    check("clear_rd1", rd_data_o[1], 0);
    check("clear_mem_zero", nonzero_words(), 0);

    write_word(5'd5, 32'h12345678);
    read_port0(5'd5);
    check("pre_bist_rd0", rd_data_o[0], 32'h12345678);

    // Clean run with functional traffic and a repeated start while busy.
    start_bist(1'b1, 1'b0, '0);
    check("bist_busy_after_start", bist_busy_o, 1);
    finish_bist(1'b1);
    check("bist_rd_hold", rd_data_o[0], 32'h12345678);

    // Abort with clear at busy cycle 50.
    start_bist(1'b0, 1'b0, '0);
    check("pass_cleared_at_start", bist_pass_o, 0);
    for (int i = 1; i < 50; i++) step();
    check("bist_pattern_visible", mem_content_o[0], 32'hFFFFFFFF);
    clear_i = 1'b1;
    step();
    clear_i = 1'b0;
    check("abort_busy", bist_busy_o, 0);
    check("abort_pass", bist_pass_o, 0);
    done_cnt = 0;
    for (int i = 0; i < 10; i++) begin
      if (bist_done_o) done_cnt++;
      step();
    end
    check("abort_no_done", done_cnt, 0);
    check("abort_mem_zero", nonzero_words(), 0);
    void'(bist_q.pop_front());

    // Stuck-at-0 on bit 0 of word 9: first miscompare is during M2 at address 9.
    write_word(5'd5, 32'h12345678);
    read_port0(5'd5);
    dbg_stuck_en_i   = 1'b1;
    dbg_stuck_addr_i = 5'd9;
    start_bist(1'b0, 1'b1, 5'd9);
    finish_bist(1'b0);

    // Reset in the middle of a failing run.
    start_bist(1'b0, 1'b0, '0);
    for (int i = 1; i < 100; i++) step();
    check("midrun_fail_addr", bist_fail_addr_o, 9);
    check("midrun_rd0", rd_data_o[0], 32'h12345678);
    rst_ni = 1'b0;
    step();
    rst_ni = 1'b1;
    dbg_stuck_en_i = 1'b0;
    void'(bist_q.pop_front());
    check("midrst_busy", bist_busy_o, 0);
    check("midrst_done", bist_done_o, 0);
    check("midrst_pass", bist_pass_o, 0);
    check("midrst_fail_addr", bist_fail_addr_o, 0);
    check("midrst_rd0", rd_data_o[0], 0);
    check("midrst_mem_zero", nonzero_words(), 0);
    step();

    start_bist(1'b1, 1'b1, '0);
    finish_bist(1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
